// File: rtl/alarm_pkg.sv
// Shared constants and FSM state type for the multi-slot alarm store.
package alarm_pkg;

    localparam int HOURS_MOD = 24;
    localparam int MINS_MOD  = 60;
    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;

    // BCD digit widths for the HH:MM display
    localparam int H1_W = 2;
    localparam int H2_W = 4;
    localparam int M1_W = 3;
    localparam int M2_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_e;

endpackage

// File: rtl/Up_Down_Mod_Counter.sv
// Modulo-MOD up/down counter with wrap in both directions; upDown=1 counts down.
module Up_Down_Mod_Counter #(
    parameter int MOD = 24,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         upDown,
    output logic [W-1:0] q
);

    // count with wrap-around: MOD-1 -> 0 going up, 0 -> MOD-1 going down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            if (upDown) begin
                q <= (q == '0) ? W'(MOD - 1) : q - 1'b1;
            end else begin
                q <= (q == W'(MOD - 1)) ? '0 : q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot alarm store and ring controller.
// Optional feature macro: ALARM_SNOOZE_EN (adds the SNOOZE state and snooze counter).
//
// state  | meaning
// IDLE   | waiting for a minute tick that matches an armed slot
// RING   | alarm sounding for slot ring_id, ring_cnt counts unattended minutes
// SNOOZE | ring paused, snz_cnt counts minutes until ringing resumes
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS       = 4,
    parameter int SEL_W            = 2,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  sel,
    input  logic              en_h,
    input  logic              en_m,
    input  logic              up,
    input  logic              down,
    input  logic              arm_toggle,
    input  logic [HOUR_W-1:0] cur_h,
    input  logic [MIN_W-1:0]  cur_m,
    input  logic              min_tick,
    input  logic              snooze,
    input  logic              dismiss,
    output logic [H1_W-1:0]   H1,
    output logic [H2_W-1:0]   H2,
    output logic [M1_W-1:0]   M1,
    output logic [M2_W-1:0]   M2,
    output logic              armed,
    output logic              ringing,
    output logic              snoozing,
    output logic [SEL_W-1:0]  ring_id
);

    localparam int RC_W = $clog2(RING_TIMEOUT_MIN + 1);

    logic [HOUR_W-1:0]     hour_q [NUM_ALARMS];
    logic [MIN_W-1:0]      min_q  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] armed_q;
    logic                  adj;

    assign adj = up ^ down;

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
        logic hit;
        assign hit = (32'(sel) == i);

        Up_Down_Mod_Counter #(.MOD(HOURS_MOD), .W(HOUR_W)) u_hour (
            .clk    (clk),
            .rst_n  (rst),
            .en     (hit & en_h & adj),
            .upDown (down),
            .q      (hour_q[i])
        );

        Up_Down_Mod_Counter #(.MOD(MINS_MOD), .W(MIN_W)) u_min (
            .clk    (clk),
            .rst_n  (rst),
            .en     (hit & en_m & adj),
            .upDown (down),
            .q      (min_q[i])
        );
    end

    // armed bits; a select outside the slot range matches no slot and is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (arm_toggle && (32'(sel) == i)) begin
                    armed_q[i] <= ~armed_q[i];
                end
            end
        end
    end

    logic [HOUR_W-1:0] disp_h;
    logic [MIN_W-1:0]  disp_m;

    // selected-slot mux; out-of-range select shows 00:00 disarmed
    always_comb begin
        disp_h = '0;
        disp_m = '0;
        armed  = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (32'(sel) == i) begin
                disp_h = hour_q[i];
                disp_m = min_q[i];
                armed  = armed_q[i];
            end
        end
    end

    assign H1 = H1_W'(disp_h / HOUR_W'(10));
    assign H2 = H2_W'(disp_h % HOUR_W'(10));
    assign M1 = M1_W'(disp_m / MIN_W'(10));
    assign M2 = M2_W'(disp_m % MIN_W'(10));

    logic             hit_any;
    logic [SEL_W-1:0] hit_idx;
    logic             disarm;

    // lowest-index armed slot matching the current time; scanning downward leaves the lowest
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (armed_q[i] && (hour_q[i] == cur_h) && (min_q[i] == cur_m)) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // toggling the armed bit of the ringing slot while it is armed means disarming it
    always_comb begin
        disarm = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (arm_toggle && (32'(sel) == i) && (32'(ring_id) == i) && armed_q[i]) begin
                disarm = 1'b1;
            end
        end
    end

    alarm_state_e     state, state_nx;
    logic [RC_W-1:0]  ring_cnt, ring_cnt_nx;
    logic [SEL_W-1:0] ring_id_nx;

`ifdef ALARM_SNOOZE_EN
    localparam int SC_W = $clog2(SNOOZE_MIN + 1);
    logic [SC_W-1:0] snz_cnt, snz_cnt_nx;

    // snooze countdown register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) snz_cnt <= '0;
        else      snz_cnt <= snz_cnt_nx;
    end

    assign snoozing = (state == SNOOZE);
`else
    logic unused_snooze;
    assign unused_snooze = snooze ^ SNOOZE_MIN[0];
    assign snoozing      = 1'b0;
`endif

    // FSM, ring counter and ring_id registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ring_cnt <= '0;
            ring_id  <= '0;
        end else begin
            state    <= state_nx;
            ring_cnt <= ring_cnt_nx;
            ring_id  <= ring_id_nx;
        end
    end

    // next-state: dismiss (or disarm) beats snooze beats minute tick
    always_comb begin
        state_nx    = state;
        ring_cnt_nx = ring_cnt;
        ring_id_nx  = ring_id;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_nx  = snz_cnt;
`endif
        case (state)
            IDLE: begin
                if (min_tick && hit_any) begin
                    state_nx    = RING;
                    ring_id_nx  = hit_idx;
                    ring_cnt_nx = '0;
                end
            end
            RING: begin
                if (dismiss || disarm) begin
                    state_nx = IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_nx   = SNOOZE;
                    snz_cnt_nx = SC_W'(SNOOZE_MIN);
`endif
                end else if (min_tick) begin
                    if (ring_cnt == RC_W'(RING_TIMEOUT_MIN - 1)) state_nx = IDLE;
                    else ring_cnt_nx = ring_cnt + 1'b1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (dismiss || disarm) begin
                    state_nx = IDLE;
                end else if (min_tick) begin
                    if (snz_cnt == SC_W'(1)) begin
                        state_nx    = RING;
                        ring_cnt_nx = '0;
                    end else begin
                        snz_cnt_nx = snz_cnt - 1'b1;
                    end
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    assign ringing = (state == RING);

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_alarm_bank;

    localparam int NA  = 4;
    localparam int SW  = 3;
    localparam int SNZ = 5;
    localparam int TO  = 10;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic          clk, rst;
    logic [SW-1:0] sel;
    logic          en_h, en_m, up, down, arm_toggle, min_tick, snooze, dismiss;
    logic [4:0]    cur_h;
    logic [5:0]    cur_m;
    logic [1:0]    H1;
    logic [3:0]    H2;
    logic [2:0]    M1;
    logic [3:0]    M2;
    logic          armed, ringing, snoozing;
    logic [SW-1:0] ring_id;

    int n_cmp = 0;
    int n_bad = 0;

    alarm_bank #(.NUM_ALARMS(NA), .SEL_W(SW), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(TO)) dut (
        .clk(clk), .rst(rst), .sel(sel), .en_h(en_h), .en_m(en_m), .up(up), .down(down),
        .arm_toggle(arm_toggle), .cur_h(cur_h), .cur_m(cur_m), .min_tick(min_tick),
        .snooze(snooze), .dismiss(dismiss), .H1(H1), .H2(H2), .M1(M1), .M2(M2),
        .armed(armed), .ringing(ringing), .snoozing(snoozing), .ring_id(ring_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: slot times as plain integers, ring activity as flags and minute counts
    int mh [NA];
    int mm [NA];
    bit ma [NA];
    bit m_ring, m_snz;
    int m_id, m_rang, m_left;
    bit mv, mk;
    int ms;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NA; i++) begin
                mh[i] = 0; mm[i] = 0; ma[i] = 0;
            end
            m_ring = 0; m_snz = 0; m_id = 0; m_rang = 0; m_left = 0;
        end else begin
            ms = int'(sel);
            mv = (ms < NA);
            mk = (m_ring || m_snz) && arm_toggle && mv && (ms == m_id) && ma[m_id];
            if (m_ring) begin
                if (dismiss || mk) m_ring = 0;
                else if (SNZ_EN && snooze) begin
                    m_ring = 0; m_snz = 1; m_left = SNZ;
                end else if (min_tick) begin
                    m_rang = m_rang + 1;
                    if (m_rang == TO) m_ring = 0;
                end
            end else if (m_snz) begin
                if (dismiss || mk) m_snz = 0;
                else if (min_tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_snz = 0; m_ring = 1; m_rang = 0;
                    end
                end
            end else if (min_tick) begin
                for (int i = NA - 1; i >= 0; i--) begin
                    if (ma[i] && mh[i] == int'(cur_h) && mm[i] == int'(cur_m)) begin
                        m_ring = 1; m_id = i; m_rang = 0;
                    end
                end
            end
            if (mv && (up != down)) begin
                if (en_h) mh[ms] = (mh[ms] + (up ? 1 : 23)) % 24;
                if (en_m) mm[ms] = (mm[ms] + (up ? 1 : 59)) % 60;
            end
            if (mv && arm_toggle) ma[ms] = !ma[ms];
        end
    end

    task automatic cmp_model();
        int h, m;
        bit a;
        logic [18:0] exp_v, act_v;
        h = 0; m = 0; a = 0;
        if (int'(sel) < NA) begin
            h = mh[sel]; m = mm[sel]; a = ma[sel];
        end
        exp_v = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), a, m_ring, m_snz, 3'(m_id)};
        act_v = {H1, H2, M1, M2, armed, ringing, snoozing, ring_id};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act_v, exp_v);
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cmp_model();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        en_h = 0; en_m = 0; up = 0; down = 0; arm_toggle = 0;
        min_tick = 0; snooze = 0; dismiss = 0;
    endtask

    task automatic edit(input int s, input bit eh, input bit em, input bit u, input bit d, input int n);
        repeat (n) begin
            sel = SW'(s); en_h = eh; en_m = em; up = u; down = d;
            cyc();
        end
        clr();
    endtask

    task automatic tick(input int h, input int m, input int n);
        repeat (n) begin
            cur_h = 5'(h); cur_m = 6'(m); min_tick = 1;
            cyc();
            min_tick = 0;
            cyc();
        end
    endtask

    task automatic arm(input int s);
        sel = SW'(s); arm_toggle = 1;
        cyc();
        arm_toggle = 0;
    endtask

    initial begin
        int k;
        rst = 0; sel = '0; cur_h = '0; cur_m = '0;
        clr();
        #12;
        check("rst_digits", int'({H1, H2, M1, M2}), 0);
        check("rst_flags", int'({armed, ringing, snoozing, ring_id}), 0);
        #11 rst = 1;
        @(posedge clk); #1;

        edit(1, 1, 0, 0, 1, 3);
        check("h_down_H1", int'(H1), 2);
        check("h_down_H2", int'(H2), 1);
        edit(1, 0, 1, 0, 1, 1);
        check("m_down_M1", int'(M1), 5);
        check("m_down_M2", int'(M2), 9);
        edit(1, 1, 1, 1, 1, 2);
        check("updown_same", int'({H1, H2, M1, M2}), int'({2'd2, 4'd1, 3'd5, 4'd9}));

        edit(7, 1, 1, 1, 0, 2);
        arm(7);
        check("oor_digits", int'({H1, H2, M1, M2}), 0);
        check("oor_armed", int'(armed), 0);
        sel = 3'd3; #1;
        check("oor_slot3", int'({H1, H2, M1, M2, armed}), 0);
        sel = 3'd1; #1;
        check("oor_slot1_kept", int'({H1, H2}), int'({2'd2, 4'd1}));

        edit(0, 1, 0, 1, 0, 7);
        edit(0, 0, 1, 0, 1, 30);
        check("slot0_0730", int'({H1, H2, M1, M2}), int'({2'd0, 4'd7, 3'd3, 4'd0}));
        tick(7, 30, 1);
        check("disarmed_no_ring", int'(ringing), 0);
        arm(0);
        edit(2, 1, 0, 1, 0, 7);
        edit(2, 0, 1, 0, 1, 30);
        arm(2);

        cur_h = 5'd7; cur_m = 6'd30; min_tick = 1;
        cyc();
        min_tick = 0;
        check("ring_start", int'(ringing), 1);
        check("ring_id_low", int'(ring_id), 0);
        cyc();
        tick(7, 30, 9);
        check("ring_before_timeout", int'(ringing), 1);
        tick(7, 30, 1);
        check("ring_timeout", int'(ringing), 0);

        tick(7, 30, 1);
        check("ring_again", int'(ringing), 1);
        dismiss = 1; snooze = 1;
        cyc();
        clr();
        check("dismiss_beats_snooze", int'({ringing, snoozing}), 0);

        tick(7, 30, 1);
        snooze = 1;
        cyc();
        clr();
`ifdef ALARM_SNOOZE_EN
        check("snooze_enter", int'({ringing, snoozing}), 1);
        tick(7, 30, 4);
        check("snooze_4th", int'({ringing, snoozing}), 1);
        tick(7, 30, 1);
        check("snooze_5th", int'({ringing, snoozing}), 2);
`else
        check("snooze_ignored", int'({ringing, snoozing}), 2);
`endif
        dismiss = 1;
        cyc();
        clr();

        tick(7, 30, 1);
        check("ring_disarm_pre", int'(ringing), 1);
        arm(0);
        check("disarm_stops", int'(ringing), 0);
        check("disarm_armed", int'(armed), 0);

        tick(7, 30, 1);
        check("ring_id_slot2", int'(ring_id), 2);
        edit(2, 1, 0, 1, 0, 1);
        check("edit_keeps_ring", int'(ringing), 1);
        #3 rst = 0;
        #1;
        check("arst_flags", int'({ringing, snoozing, ring_id}), 0);
        check("arst_slot", int'({H1, H2, M1, M2, armed}), 0);
        #3 rst = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 3000; i++) begin
            sel        = SW'($urandom_range(7, 0));
            en_h       = ($urandom_range(9, 0) < 4);
            en_m       = ($urandom_range(9, 0) < 4);
            up         = ($urandom_range(9, 0) < 3);
            down       = ($urandom_range(9, 0) < 3);
            arm_toggle = ($urandom_range(99, 0) < 8);
            min_tick   = ($urandom_range(99, 0) < 25);
            snooze     = ($urandom_range(99, 0) < 8);
            dismiss    = ($urandom_range(99, 0) < 3);
            if ($urandom_range(1, 0) == 1) begin
                k = int'($urandom_range(NA - 1, 0));
                cur_h = 5'(mh[k]);
                cur_m = 6'(mm[k]);
            end else begin
                cur_h = 5'($urandom_range(23, 0));
                cur_m = 6'($urandom_range(59, 0));
            end
            cyc();
        end
        clr();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Multi-slot alarm store and ring controller for the digital alarm clock.
- Holds NUM_ALARMS independently armed HH:MM alarm times, edited one slot at a time with up/down pulses.
- Compares armed slots against the timekeeping block's current time on each minute tick and drives ring/snooze/dismiss behaviour.
- Feeds the selected slot's BCD digits to the display mux.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..2**SEL_W).
- SEL_W, 2, width of slot select and ring_id.
- SNOOZE_MIN, 5, snooze length in minutes (>=1).
- RING_TIMEOUT_MIN, 10, minutes of unattended ringing before auto-stop (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- sel  in  SEL_W  slot being edited/displayed.
- en_h  in  1  hour edit enable.
- en_m  in  1  minute edit enable.
- up  in  1  one-cycle increment pulse (debounced upstream).
- down  in  1  one-cycle decrement pulse.
- arm_toggle  in  1  one-cycle pulse; toggles armed bit of slot sel.
- cur_h  in  5  current hour, binary 0..23.
- cur_m  in  6  current minute, binary 0..59.
- min_tick  in  1  one-cycle pulse; cur_h/cur_m already hold the new minute in that cycle.
- snooze  in  1  one-cycle snooze request.
- dismiss  in  1  one-cycle dismiss request.
- H1  out  2  tens of hours, selected slot.
- H2  out  4  units of hours.
- M1  out  3  tens of minutes.
- M2  out  4  units of minutes.
- armed  out  1  armed bit of selected slot.
- ringing  out  1  high in RING.
- snoozing  out  1  high in SNOOZE.
- ring_id  out  SEL_W  slot that triggered the current ring.

Behaviour:
- Reset (rst=0, async): all slots 00:00 and disarmed; FSM IDLE; ring_cnt=0; snz_cnt=0; ring_id=0; ringing=snoozing=0; digit outputs 0.
- Edit:
  - en_h with exactly one of up/down: hour of slot sel changes +/-1 mod 24 (23->0 on up, 0->23 on down).
  - en_m does the same for minutes mod 60.
  - en_h and en_m together: both fields adjust in the same cycle.
  - up and down together: no change.
  - Result is visible on the digit outputs one cycle later.
- Display: H1/H2/M1/M2 and armed are combinational decodes (/10, %10) of the selected slot registers.
- Out-of-range sel (>=NUM_ALARMS): edits and arm_toggle are ignored; outputs show 00:00 with armed=0.
- Editing a slot never affects an ongoing ring or snooze.
- FSM states: IDLE, RING, SNOOZE. Outputs ringing, snoozing and ring_id are registered.
- IDLE:
  - On min_tick, find armed slots whose time equals cur_h:cur_m.
  - If any match, go to RING with ring_id = lowest matching index and ring_cnt=0.
  - Other matching slots are dropped.
- RING:
  - Priority is dismiss > snooze > tick.
  - dismiss -> IDLE.
  - snooze -> SNOOZE with snz_cnt=SNOOZE_MIN.
  - min_tick: ring_cnt+1; if ring_cnt==RING_TIMEOUT_MIN-1, go to IDLE instead.
- SNOOZE:
  - dismiss -> IDLE.
  - snooze is ignored.
  - min_tick: snz_cnt-1; if snz_cnt==1, go to RING with ring_cnt=0.
- While in RING or SNOOZE, new matches from any slot are ignored and are not queued.
- arm_toggle that disarms slot ring_id while in RING or SNOOZE acts as dismiss, in the same cycle.
- Counter widths are $clog2(param+1); there is no overflow path.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined: SNOOZE state and snz_cnt exist as described above.
- Undefined: snooze input is ignored; SNOOZE is unreachable; snoozing is tied to 0; RING exits only via dismiss, disarm or timeout.

Decomposition:
- Shared package alarm_pkg holds:
  - HOURS_MOD=24, MINS_MOD=60, HOUR_W=5, MIN_W=6.
  - State enum {IDLE, RING, SNOOZE}.
  - Digit widths for H1/H2/M1/M2.
- Sub-module: reuse the existing Up_Down_Mod_Counter, two per slot in a generate loop (hours and minutes).
  - Enable: (sel==i) & en_x & (up^down).
  - upDown = down.
- Compare, priority encoder and FSM stay in alarm_bank.

Test Plan:
- Reset, then sel=1, en_h, 3x down -> H1=2, H2=1 (21); en_m, 1x down -> M1=5, M2=9.
- Up and down asserted together -> digits unchanged. sel=7 with NUM_ALARMS=4 plus edit pulses -> no slot changes; outputs 00:00.
- Slots 0 and 2 armed at 07:30; min_tick with cur=07:30 -> ringing=1 next cycle, ring_id=0. Disarmed slot at 07:30 -> no ring.
- RING; snooze; 5 min_ticks -> snoozing=1 through the 4th tick, ringing=1 after the 5th. dismiss and snooze in the same cycle -> IDLE.
- RING with no input for 10 min_ticks -> IDLE after the 10th.
- rst low mid-RING -> all outputs and slots return to reset values asynchronously.
